// File: rtl/mem_responder_multi.sv
// Unified instruction/data memory responder for the multicycle RV32I core: single-beat
// requests, programmable wait states, byte/half/word lanes, load extension, fault detection.
// Optional access counters (oReadCount/oWriteCount) are built when MEM_ACCESS_COUNT_EN is defined.
`timescale 1ns/1ps

module mem_responder_multi #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oReadData,
  output logic        oMemReady,
  output logic        oFault,
  output logic        oBusy
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] oReadCount,
  output logic [31:0] oWriteCount
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int              DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [32:0]     MEM_BYTES = 33'd4 << ADDR_WIDTH;
  localparam int              CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  // Control and latched-request state
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [31:0]           wdata_q, wdata_d;

  // Response registers
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  fault_out_q, fault_out_d;

  logic [31:0]           mem_q [DEPTH];
  logic                  mem_we;

  logic [31:0]           req_offset;
  logic                  req_range_bad, req_align_bad, req_code_bad;
  logic [31:0]           cur_word, merged_word, load_word;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic                  entering_resp;

  // Fault classification of the incoming request, captured only when IDLE latches it
  always_comb begin
    req_offset    = iAddress - BASE_ADDR;
    req_range_bad = ({1'b0, req_offset} >= MEM_BYTES);
    req_align_bad = ((iFunct3[1:0] == 2'b01) && iAddress[0]) ||
                    ((iFunct3[1:0] == 2'b10) && (iAddress[1:0] != 2'b00));
    if (iMemWrite) begin
      req_code_bad = iFunct3[2] || (iFunct3[1:0] == 2'b11);
    end else begin
      req_code_bad = (iFunct3 == 3'b011) || (iFunct3 == 3'b110) || (iFunct3 == 3'b111);
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    fault_d    = fault_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (iMemRead || iMemWrite) begin
          is_write_d = iMemWrite;
          fault_d    = req_range_bad || req_align_bad || req_code_bad;
          idx_d      = req_offset[ADDR_WIDTH+1:2];
          lane_d     = iAddress[1:0];
          funct3_d   = iFunct3;
          wdata_d    = iWriteData;
          cnt_d      = '0;
          state_d    = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_LAST) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane datapath works off the _d view so the zero-wait path sees the request being latched
  always_comb begin
    cur_word    = mem_q[idx_d];
    lane_byte   = cur_word[{lane_d, 3'b000} +: 8];
    lane_half   = cur_word[{lane_d[1], 4'b0000} +: 16];

    merged_word = cur_word;
    case (funct3_d[1:0])
      2'b00:   merged_word[{lane_d, 3'b000} +: 8]     = wdata_d[7:0];
      2'b01:   merged_word[{lane_d[1], 4'b0000} +: 16] = wdata_d[15:0];
      default: merged_word = wdata_d;
    endcase

    case (funct3_d)
      3'b000:  load_word = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_word = {24'h0, lane_byte};
      3'b001:  load_word = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_word = {16'h0, lane_half};
      3'b010:  load_word = cur_word;
      default: load_word = '0;
    endcase
  end

  // Commit and load happen on the edge that enters RESP
  always_comb begin
    entering_resp = (state_d == S_RESP);
    ready_d       = entering_resp;
    fault_out_d   = entering_resp && fault_d;
    rdata_d       = rdata_q;
    mem_we        = 1'b0;
    if (entering_resp) begin
      if (is_write_d) begin
        mem_we = !fault_d && !iRST;
      end else begin
        rdata_d = fault_d ? '0 : load_word;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      fault_q     <= 1'b0;
      idx_q       <= '0;
      lane_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      fault_out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      fault_q     <= fault_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      fault_out_q <= fault_out_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive iRST and it maps onto plain RAM.
  always_ff @(posedge iCLK) begin
    if (mem_we) mem_q[idx_d] <= merged_word;
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if ((state_q == S_RESP) && !fault_q) begin
      if (is_write_q) wr_count_d = wr_count_q + 32'd1;
      else            rd_count_d = rd_count_q + 32'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign oReadCount  = rd_count_q;
  assign oWriteCount = wr_count_q;
`endif

  assign oReadData = rdata_q;
  assign oMemReady = ready_q;
  assign oFault    = fault_out_q;
  assign oBusy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder_multi.sv
// Self-checking bench for mem_responder_multi: byte-level memory model plus per-cycle compare,
// directed transactions with literal expectations, and a second zero-wait-state instance.
`timescale 1ns/1ps

module tb_mem_responder_multi;

  localparam int          AW          = 10;
  localparam int          W           = 2;
  localparam int          DEPTH_BYTES = 4 << AW;
  localparam logic [31:0] BASE        = 32'h0000_0000;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready, fault, busy;

  logic        z_read, z_write;
  logic [31:0] z_addr, z_wdata;
  logic [2:0]  z_funct3;
  logic [31:0] z_rdata;
  logic        z_ready, z_fault, z_busy;

  mem_responder_multi #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .iCLK(clk), .iRST(rst), .iMemRead(mem_read), .iMemWrite(mem_write),
    .iAddress(addr), .iWriteData(wdata), .iFunct3(funct3),
    .oReadData(rdata), .oMemReady(ready), .oFault(fault), .oBusy(busy)
  );

  mem_responder_multi #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
    .iCLK(clk), .iRST(rst), .iMemRead(z_read), .iMemWrite(z_write),
    .iAddress(z_addr), .iWriteData(z_wdata), .iFunct3(z_funct3),
    .oReadData(z_rdata), .oMemReady(z_ready), .oFault(z_fault), .oBusy(z_busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  mb [DEPTH_BYTES];
  bit          chk_on     = 1'b0;
  bit          txn_active = 1'b0;
  int          exp_start  = 0;
  bit          txn_fault  = 1'b0;
  logic [31:0] txn_rdata  = '0;
  logic [31:0] hold_rdata = '0;
  logic [31:0] last_rdata;
  logic        last_fault;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int msize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit mfault(input bit wr, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] off = a - BASE;
    if (off >= 32'(DEPTH_BYTES)) return 1'b1;
    if (wr) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (!(f3 inside {LB, LH, LW, LBU, LHU})) begin
      return 1'b1;
    end
    if ((a % 32'(msize(f3))) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] f3);
    int          n   = msize(f3);
    int          off = int'(a - BASE);
    logic [31:0] v   = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[off + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int n   = msize(f3);
    int off = int'(a - BASE);
    for (int i = 0; i < n; i++) mb[off + i] = wd[8 * i +: 8];
  endtask

  // Per-cycle comparison against the model's transaction window
  always @(negedge clk) begin : cmp
    bit          e_rdy, e_busy;
    logic [31:0] e_rd;
    if (chk_on) begin
      e_rdy  = txn_active && (cyc == exp_start + W);
      e_busy = txn_active && (cyc >= exp_start) && (cyc <= exp_start + W);
      e_rd   = (txn_active && (cyc >= exp_start + W)) ? txn_rdata : hold_rdata;
      check("ready", 32'(ready), 32'(e_rdy));
      check("busy", 32'(busy), 32'(e_busy));
      check("fault", 32'(fault), 32'(e_rdy && txn_fault));
      check("rdata", rdata, e_rd);
      if (ready) begin
        last_rdata = rdata;
        last_fault = fault;
      end
    end
  end

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input bit toggle);
    int n;
    bit f;
    @(posedge clk); #2;
    last_rdata = 'x;
    last_fault = 1'bx;
    mem_read = rd; mem_write = wr; addr = a; funct3 = f3; wdata = wd;
    n = cyc + 1;
    f = mfault(wr, a, f3);
    txn_fault  = f;
    txn_rdata  = wr ? hold_rdata : (f ? 32'h0 : mload(a, f3));
    exp_start  = n;
    txn_active = 1'b1;
    @(posedge clk); #2;
    if (toggle) begin
      for (int i = 0; i < W; i++) begin
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        addr      = $urandom;
        funct3    = 3'($urandom);
        wdata     = $urandom;
        @(posedge clk); #2;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    while (cyc < n + W + 1) begin
      @(posedge clk); #2;
    end
    if (wr && !f) mstore(a, f3, wd);
    hold_rdata = txn_rdata;
    txn_active = 1'b0;
  endtask

  task automatic expect_last(input string name, input logic [31:0] er, input bit ef);
    check({name, " data"}, last_rdata, er);
    check({name, " fault"}, 32'(last_fault), 32'(ef));
  endtask

  task automatic do_abort(input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #2;
    mem_write = 1'b1; addr = a; funct3 = SW; wdata = wd;
    exp_start = cyc + 1; txn_fault = 1'b0; txn_rdata = hold_rdata; txn_active = 1'b1;
    @(posedge clk); #2;
    mem_write = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; txn_active = 1'b0; hold_rdata = '0;
    @(negedge clk);
    check("abort rdata", rdata, 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort ready", 32'(ready), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic z_txn(input string name, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] er, input bit ef);
    @(posedge clk); #2;
    z_read = !wr; z_write = wr; z_addr = a; z_funct3 = f3; z_wdata = wd;
    @(negedge clk);
    check({name, " ready before"}, 32'(z_ready), 32'h0);
    @(posedge clk); #2;
    z_read = 1'b0; z_write = 1'b0;
    @(negedge clk);
    check({name, " ready"}, 32'(z_ready), 32'h1);
    check({name, " busy"}, 32'(z_busy), 32'h1);
    check({name, " fault"}, 32'(z_fault), 32'(ef));
    if (!wr) check({name, " data"}, z_rdata, er);
    @(negedge clk);
    check({name, " ready after"}, 32'(z_ready), 32'h0);
    check({name, " busy after"}, 32'(z_busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH_BYTES; i++) mb[i] = 8'h00;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    z_read = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0; z_funct3 = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset ready", 32'(ready), 32'h0);
    check("reset fault", 32'(fault), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset z_busy", 32'(z_busy), 32'h0);
    chk_on = 1'b1;

    // Word write/read
    do_txn(0, 1, 32'h0000, SW, 32'hA5A5_A5A5, 0);
    do_txn(0, 1, 32'h0010, SW, 32'hDEAD_BEEF, 0);
    do_txn(1, 0, 32'h0010, LW, 32'h0, 0);
    expect_last("lw 0x10", 32'hDEAD_BEEF, 0);

    // Byte lane
    do_txn(0, 1, 32'h0011, SB, 32'h0000_0080, 0);
    do_txn(1, 0, 32'h0011, LB, 32'h0, 0);
    expect_last("lb 0x11", 32'hFFFF_FF80, 0);
    do_txn(1, 0, 32'h0011, LBU, 32'h0, 0);
    expect_last("lbu 0x11", 32'h0000_0080, 0);
    do_txn(1, 0, 32'h0010, LW, 32'h0, 0);
    expect_last("lw after sb", 32'hDEAD_80EF, 0);

    // Half lane and misaligned half
    do_txn(0, 1, 32'h0012, SH, 32'h0000_8001, 0);
    do_txn(1, 0, 32'h0012, LH, 32'h0, 0);
    expect_last("lh 0x12", 32'hFFFF_8001, 0);
    do_txn(1, 0, 32'h0012, LHU, 32'h0, 0);
    expect_last("lhu 0x12", 32'h0000_8001, 0);
    do_txn(1, 0, 32'h0013, LH, 32'h0, 0);
    expect_last("lh 0x13", 32'h0, 1);
    do_txn(1, 0, 32'h0010, LW, 32'h0, 0);
    expect_last("lw after sh", 32'h8001_80EF, 0);

    // Range, code and alignment faults
    do_txn(0, 1, 32'h1000, SW, 32'h1111_1111, 0);
    expect_last("sw 0x1000", 32'h8001_80EF, 1);
    do_txn(1, 0, 32'h0000, LW, 32'h0, 0);
    expect_last("word0 kept", 32'hA5A5_A5A5, 0);
    do_txn(1, 0, 32'h0010, 3'b011, 32'h0, 0);
    expect_last("read f3 011", 32'h0, 1);
    do_txn(0, 1, 32'h0012, SW, 32'h2222_2222, 0);
    do_txn(0, 1, 32'h0010, 3'b100, 32'h3333_3333, 0);
    do_txn(1, 0, 32'h0010, LW, 32'h0, 0);
    expect_last("faulted stores", 32'h8001_80EF, 0);
    do_txn(0, 1, 32'h0FFC, SW, 32'h0C0F_FEE0, 0);
    do_txn(1, 0, 32'h0FFC, LW, 32'h0, 0);
    expect_last("last word", 32'h0C0F_FEE0, 0);
    do_txn(1, 0, 32'hFFFF_FFFC, LW, 32'h0, 0);
    expect_last("below base", 32'h0, 1);

    // Read and write together, requests toggled while waiting
    do_txn(1, 0, 32'h0013, LB, 32'h0, 0);
    do_txn(1, 1, 32'h0020, SW, 32'h0000_0055, 1);
    expect_last("rd+wr hold", 32'hFFFF_FF80, 0);
    do_txn(1, 0, 32'h0020, LW, 32'h0, 0);
    expect_last("lw 0x20", 32'h0000_0055, 0);

    // Reset while waiting drops the pending write
    do_txn(0, 1, 32'h0030, SW, 32'h0BAD_F00D, 0);
    do_txn(1, 0, 32'h0030, LW, 32'h0, 0);
    do_abort(32'h0030, 32'h1234_5678);
    do_txn(1, 0, 32'h0030, LW, 32'h0, 0);
    expect_last("lw after abort", 32'h0BAD_F00D, 0);

    // Zero-wait-state instance
    z_txn("z sw", 1, 32'h0040, SW, 32'hCAFE_F00D, 32'h0, 0);
    z_txn("z lw", 0, 32'h0040, LW, 32'h0, 32'hCAFE_F00D, 0);
    z_txn("z lhu", 0, 32'h0042, LHU, 32'h0, 32'h0000_CAFE, 0);
    z_txn("z lw mis", 0, 32'h0041, LW, 32'h0, 32'h0, 1);

    repeat (2) @(posedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
